// File: rtl/dm_ctrl_pkg.sv
// Shared constants and payload types for the data-memory responder.
// Size encodings match the core's memory-stage control.
package dm_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [SIZE_W-1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    size_e             size;
    logic              sign;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering: merges store data into the old word, extracts and
// extends load data, and flags misaligned or illegal-size accesses.
module dm_lane
  import dm_ctrl_pkg::*;
(
  input  size_e             size,
  input  logic              sign,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] old_word,
  output logic [DATA_W-1:0] wword_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              misaligned_c
);

  logic [4:0]  sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    wword_c      = old_word;
    rdata_c      = '0;
    misaligned_c = 1'b0;
    sh           = '0;
    byte_v       = '0;
    half_v       = '0;
    unique case (size)
      SZ_BYTE: begin
        sh      = {off, 3'b000};
        byte_v  = 8'(old_word >> sh);
        wword_c = (old_word & ~(DATA_W'(8'hFF) << sh)) | (DATA_W'(wdata[7:0]) << sh);
        rdata_c = {{24{sign & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        misaligned_c = off[0];
        sh      = {off[1], 4'b0000};
        half_v  = 16'(old_word >> sh);
        wword_c = (old_word & ~(DATA_W'(16'hFFFF) << sh)) | (DATA_W'(wdata[15:0]) << sh);
        rdata_c = {{16{sign & half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        misaligned_c = (off != 2'b00);
        wword_c      = wdata;
        rdata_c      = old_word;
      end
      default: misaligned_c = 1'b1;
    endcase
    // Faulting accesses leave the word untouched and return zero.
    if (misaligned_c) begin
      wword_c = old_word;
      rdata_c = '0;
    end
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory responder: one request at a time, programmable wait states,
// single-cycle response pulse with extended load data.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dm_req_t           req_q, req_d, cur;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] widx;
  logic [DATA_W-1:0] old_word, wword, lane_rdata, resp_rdata_d;
  logic              misaligned, access, accept, wr_en;
  logic              req_ready_d, resp_valid_d, resp_err_d;
  logic              unused_addr;

  assign accept = req_valid && req_ready;

  // In IDLE the live request drives the lanes so a zero-wait access can
  // complete on the acceptance edge; afterwards the latched copy does.
  always_comb begin
    cur = req_q;
    if (state_q == IDLE) begin
      cur.we    = req_we;
      cur.size  = size_e'(req_size);
      cur.sign  = req_sign;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
    end
  end

  assign widx        = cur.addr[ADDR_W+1:2];
  assign old_word    = mem[widx];
  assign unused_addr = ^cur.addr[DATA_W-1:ADDR_W+2];

  dm_lane u_lane (
    .size         (cur.size),
    .sign         (cur.sign),
    .off          (cur.addr[1:0]),
    .wdata        (cur.wdata),
    .old_word     (old_word),
    .wword_c      (wword),
    .rdata_c      (lane_rdata),
    .misaligned_c (misaligned)
  );

  // Next-state and registered-output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    access       = 1'b0;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = cur;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    if (access) begin
      resp_err_d   = misaligned;
      resp_rdata_d = (cur.we || misaligned) ? '0 : lane_rdata;
    end
  end

  assign wr_en = access && cur.we && !misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= wword;
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: three instances (1, 0 and 3 wait states), a table of
// directed vectors, latency/backpressure and reset-abort sequences, and
// randomized traffic against a byte-addressed reference model.
module tb_dm_ctrl;

  localparam int NI = 3;
  localparam int W_OF [NI] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic        rst        [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [1:0]  req_size   [NI];
  logic        req_sign   [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  int checks = 0;
  int failures = 0;
  bit [7:0] mb [int];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dm_ctrl #(.ADDR_W(10), .WAIT_CYCLES(W_OF[g])) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_size   (req_size[g]),
      .req_sign   (req_sign[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  typedef struct {
    int          inst;
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, alignment = address multiple of size.
  function automatic void model(input int i, input logic we, input logic [1:0] sz,
                                input logic sg, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int unsigned ba, nb;
    int key;
    logic [31:0] v;
    ba  = a & 32'h0000_0FFF;
    nb  = 1 << sz;
    key = i * 65536 + int'(ba);
    er  = (sz == 2'd3) || ((ba % nb) != 0);
    rd  = 32'h0;
    if (!er) begin
      if (we) begin
        for (int k = 0; k < int'(nb); k++) mb[key + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < int'(nb); k++)
          v |= 32'(mb.exists(key + k) ? mb[key + k] : 8'h00) << (8 * k);
        if (sg && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        rd = v;
      end
    end
  endfunction

  task automatic drive(input int i, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_issue", 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_size[i]  = sz;
    req_sign[i]  = sg;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    req_we[i]    = 1'($urandom);
    req_size[i]  = 2'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
  endtask

  task automatic do_req(input int i, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    drive(i, we, sz, sg, a, wd);
    lat = 1;
    while (!resp_valid[i] && lat < 40) begin
      chk("ready_low_busy", 32'(req_ready[i]), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("resp_valid", 32'(resp_valid[i]), 32'd1);
    chk("ready_low_resp", 32'(req_ready[i]), 32'd0);
    rd = resp_rdata[i];
    er = resp_err[i];
  endtask

  task automatic xact(input int i, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    do_req(i, we, sz, sg, a, wd, rd, er, lat);
    model(i, we, sz, sg, a, wd, erd, eer);
    chk($sformatf("rdata i%0d a=%h", i, a), rd, erd);
    chk($sformatf("err i%0d a=%h", i, a), 32'(er), 32'(eer));
    chk($sformatf("latency i%0d", i), 32'(lat), 32'(W_OF[i] + 1));
  endtask

  initial begin
    vec_t tbl [$];
    logic [31:0] rd, erd, held;
    logic er, eer;
    int lat, pulses;
    int acc [$];
    bit rdy;

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0;
      req_sign[i] = 1'b0; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
    end
    #12;
    for (int i = 0; i < NI; i++) begin
      chk("reset_ready", 32'(req_ready[i]), 32'd1);
      chk("reset_valid", 32'(resp_valid[i]), 32'd0);
      chk("reset_rdata", resp_rdata[i], 32'h0);
      chk("reset_err", 32'(resp_err[i]), 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;

    // Directed vectors on the 1-wait-state instance.
    tbl.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h40,   32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd0, 1'b0, 32'h41,   32'hFFFFFF12, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'hDEAD12EF, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b1, 32'h43,   32'h0,        32'hFFFFFFDE, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd0, 1'b0, 32'h43,   32'h0,        32'h000000DE, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd1, 1'b0, 32'h42,   32'hABCD8001, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b1, 32'h42,   32'h0,        32'hFFFF8001, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b0, 32'h42,   32'h0,        32'h00008001, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h800112EF, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h41,   32'h0,        32'h0,        1'b1});
    tbl.push_back('{0, 1'b1, 2'd1, 1'b0, 32'h43,   32'h00001234, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h800112EF, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd3, 1'b0, 32'h40,   32'h0,        32'h0,        1'b1});
    tbl.push_back('{0, 1'b1, 2'd3, 1'b0, 32'h40,   32'h55555555, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h1040, 32'h0,        32'h800112EF, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd1, 1'b1, 32'h40,   32'h0,        32'h000012EF, 1'b0});
    foreach (tbl[t]) begin
      do_req(tbl[t].inst, tbl[t].we, tbl[t].sz, tbl[t].sg, tbl[t].addr, tbl[t].wdata, rd, er, lat);
      model(tbl[t].inst, tbl[t].we, tbl[t].sz, tbl[t].sg, tbl[t].addr, tbl[t].wdata, erd, eer);
      chk($sformatf("vec%0d rdata", t), rd, tbl[t].exp_rd);
      chk($sformatf("vec%0d err", t), 32'(er), 32'(tbl[t].exp_err));
      chk($sformatf("vec%0d latency", t), 32'(lat), 32'd2);
    end

    // Response fields hold after the pulse.
    held = resp_rdata[0];
    repeat (3) @(negedge clk);
    chk("rdata_held", resp_rdata[0], held);
    chk("valid_pulse_one_cycle", 32'(resp_valid[0]), 32'd0);

    // Latency on the 0- and 3-wait instances, then held-valid issue interval.
    for (int i = 1; i < NI; i++) begin
      xact(i, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADF00D);
      xact(i, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      @(negedge clk);
      while (!req_ready[i]) @(negedge clk);
      req_valid[i] = 1'b1; req_we[i] = 1'b0; req_size[i] = 2'd2; req_addr[i] = 32'h40;
      acc.delete();
      pulses = 0;
      for (int c = 0; c < 4 * (W_OF[i] + 2); c++) begin
        rdy = req_ready[i];
        @(posedge clk);
        if (rdy) acc.push_back(c);
        #1;
        if (resp_valid[i]) pulses++;
        @(negedge clk);
      end
      req_valid[i] = 1'b0;
      chk($sformatf("accepts i%0d", i), 32'(acc.size()), 32'd4);
      for (int k = 1; k < acc.size(); k++)
        chk($sformatf("issue_gap i%0d", i), 32'(acc[k] - acc[k-1]), 32'(W_OF[i] + 2));
      chk($sformatf("pulses i%0d", i), 32'(pulses), 32'd4);
    end

    // Reset during WAIT aborts a pending store.
    xact(2, 1'b1, 2'd2, 1'b0, 32'h80, 32'h11223344);
    drive(2, 1'b1, 2'd2, 1'b0, 32'h80, 32'hCAFEF00D);
    @(posedge clk);
    #1 rst[2] = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready[2]), 32'd1);
    chk("abort_valid", 32'(resp_valid[2]), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst[2] = 1'b1;
      if (resp_valid[2]) pulses++;
    end
    chk("abort_no_resp", 32'(pulses), 32'd0);
    xact(2, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);

    // Randomized traffic over a 16-word window with random upper address bits.
    for (int i = 0; i < NI; i++) begin
      for (int w = 0; w < 16; w++) xact(i, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
      for (int n = 0; n < 60; n++)
        xact(i, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
